// File: rtl/uart_alu_intf.sv
// uart_alu_intf: FIFO-side responder placed between uart_top and an external
// combinational ALU. Pops a 3-byte command frame (operand A, operand B,
// opcode) from the RX FIFO, presents it to the ALU, and pushes the one-byte
// result into the TX FIFO.
//
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_rx_empty         RX FIFO empty flag
//   i_r_data           RX FIFO head word (first-word-fall-through)
//   o_rd_uart          RX FIFO pop strobe (combinational)
//   i_tx_full          TX FIFO full flag
//   o_wr_uart          TX FIFO push strobe (combinational)
//   o_w_data           TX FIFO write data (registered ALU result)
//   o_alu_a/b/op       registered operands and opcode for the ALU
//   i_alu_result       combinational ALU result
//   o_busy             high while a frame is partial or a result is pending
//   o_timeout_err      one-cycle pulse when a partial frame is abandoned
//
// Build option: define UART_INTF_TIMEOUT_EN to add an inter-byte idle timer
// that abandons a partial frame after TIMEOUT idle cycles. Without it the
// frame waits forever and o_timeout_err is constant 0.
//
// state  | meaning
// -------+-----------------------------------------------
// GET_A  | idle, waiting for operand A byte
// GET_B  | waiting for operand B byte
// GET_OP | waiting for opcode byte
// EXEC   | operands stable, capture ALU result this edge
// SEND   | push result when TX FIFO has room

module uart_alu_intf #(
  parameter int DBIT    = 8,
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 1000000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx_empty,
  input  logic [DBIT-1:0] i_r_data,
  output logic            o_rd_uart,
  input  logic            i_tx_full,
  output logic            o_wr_uart,
  output logic [DBIT-1:0] o_w_data,
  output logic [DBIT-1:0] o_alu_a,
  output logic [DBIT-1:0] o_alu_b,
  output logic [OP_W-1:0] o_alu_op,
  input  logic [DBIT-1:0] i_alu_result,
  output logic            o_busy,
  output logic            o_timeout_err
);

  localparam logic [2:0] GET_A  = 3'd0;
  localparam logic [2:0] GET_B  = 3'd1;
  localparam logic [2:0] GET_OP = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] SEND   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [DBIT-1:0] a_q, a_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [DBIT-1:0] wdata_q, wdata_d;
  logic            rd, wr, tmo, tmo_hit;

`ifdef UART_INTF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_wait;

  assign in_wait = (state_q == GET_B) || (state_q == GET_OP);
  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT));

  // Counts only idle cycles inside a frame; any pop, the timeout itself and
  // every other state return it to zero (GET_A holds 0, so GET_B starts at 0).
  always_comb begin
    cnt_d = '0;
    if (in_wait && i_rx_empty && !tmo_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;

  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    rd      = 1'b0;
    wr      = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      GET_A: begin
        if (!i_rx_empty) begin
          rd      = 1'b1;
          a_d     = i_r_data;
          state_d = GET_B;
        end
      end
      GET_B: begin
        // An arriving byte wins over an expiring timer.
        if (!i_rx_empty) begin
          rd      = 1'b1;
          b_d     = i_r_data;
          state_d = GET_OP;
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          state_d = GET_A;
        end
      end
      GET_OP: begin
        if (!i_rx_empty) begin
          rd      = 1'b1;
          op_d    = i_r_data[OP_W-1:0];
          state_d = EXEC;
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          state_d = GET_A;
        end
      end
      EXEC: begin
        wdata_d = i_alu_result;
        state_d = SEND;
      end
      SEND: begin
        if (!i_tx_full) begin
          wr      = 1'b1;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
    end
  end

  // Strobes are Mealy outputs; gate them so nothing moves while in reset.
  assign o_rd_uart     = rd & ~i_reset;
  assign o_wr_uart     = wr & ~i_reset;
  assign o_timeout_err = tmo & ~i_reset;
  assign o_w_data      = wdata_q;
  assign o_alu_a       = a_q;
  assign o_alu_b       = b_q;
  assign o_alu_op      = op_q;
  assign o_busy        = (state_q != GET_A);

endmodule

// File: tb/tb_uart_alu_intf.sv
// Testbench for uart_alu_intf: FWFT RX FIFO model, combinational ALU stub,
// and a frame-level scoreboard that predicts every TX byte from the bytes
// popped. Inputs change only just after a rising edge; the monitor samples
// on the falling edge.

module tb_uart_alu_intf;

  localparam int TMO = 100;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       tx_full = 1'b0;
  logic       o_rd_uart, o_wr_uart, o_busy, o_timeout_err;
  logic [7:0] o_w_data, o_alu_a, o_alu_b, alu_result;
  logic [5:0] o_alu_op;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] frame [3];
  logic [7:0] last_a, last_b;
  logic [5:0] last_op;
  logic [7:0] last_wdata = 8'h00;
  int  pop_cnt = 0;
  bit  pending = 0;
  bit  full_seen = 0;
  bit  pop_req = 0;
  int  cyc = 0;
  int  pop3_cyc = 0;
  int  last_pop_cyc = 0;
  int  tmo_cyc = 0;
  int  total_pops = 0;
  int  total_pushes = 0;
  int  total_tmo = 0;

  always #5 i_clk = ~i_clk;

  uart_alu_intf #(.DBIT(8), .OP_W(6), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_rx_empty(rx_empty), .i_r_data(r_data), .o_rd_uart(o_rd_uart),
    .i_tx_full(tx_full), .o_wr_uart(o_wr_uart), .o_w_data(o_w_data),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .i_alu_result(alu_result), .o_busy(o_busy), .o_timeout_err(o_timeout_err)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return a;
    endcase
  endfunction

  assign alu_result = alu_f(o_alu_a, o_alu_b, o_alu_op);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sync_rx();
    rx_empty = (rx_q.size() == 0);
    r_data   = rx_empty ? 8'h00 : rx_q[0];
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_q.push_back(b);
    sync_rx();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((rx_q.size() != 0 || exp_q.size() != 0 || o_busy) && n < budget) begin
      step(1);
      n++;
    end
    chk("idle_within_budget", 32'(n < budget), 32'd1);
  endtask

  // RX FIFO pop lands just after the edge that consumed the head word.
  always @(posedge i_clk) begin
    #1;
    if (pop_req) begin
      rx_q.delete(0);
      sync_rx();
    end
    pop_req = 0;
  end

  // Frame-level scoreboard.
  always @(negedge i_clk) begin
    cyc++;
    if (i_reset) begin
      chk("rd_in_reset", 32'(o_rd_uart), 32'd0);
      chk("wr_in_reset", 32'(o_wr_uart), 32'd0);
      pop_cnt = 0;
      pending = 0;
      exp_q.delete();
    end else begin
      chk("busy", 32'(o_busy), 32'((pop_cnt != 0) || pending));
      chk("rd_wr_overlap", 32'(o_rd_uart && o_wr_uart), 32'd0);
      chk("pop_when_empty", 32'(o_rd_uart && rx_empty), 32'd0);
      chk("push_when_full", 32'(o_wr_uart && tx_full), 32'd0);
      chk("pop_while_pending", 32'(o_rd_uart && pending), 32'd0);
      if (pending && tx_full) full_seen = 1;
      if (o_rd_uart && !rx_empty) begin
        pop_req = 1;
        total_pops++;
        last_pop_cyc = cyc;
        frame[pop_cnt] = rx_q[0];
        pop_cnt++;
        if (pop_cnt == 3) begin
          last_a  = frame[0];
          last_b  = frame[1];
          last_op = frame[2][5:0];
          exp_q.push_back(alu_f(last_a, last_b, last_op));
          pending   = 1;
          full_seen = 0;
          pop3_cyc  = cyc;
          pop_cnt   = 0;
        end
      end
      if (o_wr_uart) begin
        total_pushes++;
        chk("push_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("w_data", 32'(o_w_data), 32'(exp_q.pop_front()));
        chk("alu_a", 32'(o_alu_a), 32'(last_a));
        chk("alu_b", 32'(o_alu_b), 32'(last_b));
        chk("alu_op", 32'(o_alu_op), 32'(last_op));
        if (!full_seen) chk("push_latency", 32'(cyc - pop3_cyc), 32'd2);
        last_wdata = o_w_data;
        pending = 0;
      end
      if (o_timeout_err) begin
        total_tmo++;
        tmo_cyc = cyc;
        pop_cnt = 0;
      end
    end
  end

  initial begin
    int p0, w0, t0;
    logic [7:0] ops [5];
    ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24; ops[3] = 8'h25; ops[4] = 8'h26;

    // Reset state
    step(2);
    chk("rst_alu_a", 32'(o_alu_a), 32'd0);
    chk("rst_alu_b", 32'(o_alu_b), 32'd0);
    chk("rst_alu_op", 32'(o_alu_op), 32'd0);
    chk("rst_w_data", 32'(o_w_data), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_tmo", 32'(o_timeout_err), 32'd0);
    i_reset = 1'b0;
    step(1);

    // 1: basic frame
    p0 = total_pops; w0 = total_pushes;
    push_byte(8'h05); push_byte(8'h03); push_byte(8'h20);
    wait_idle(50);
    chk("t1_pops", 32'(total_pops - p0), 32'd3);
    chk("t1_pushes", 32'(total_pushes - w0), 32'd1);
    chk("t1_alu_op", 32'(o_alu_op), 32'h20);
    chk("t1_result", 32'(last_wdata), 32'h08);
    chk("t1_busy", 32'(o_busy), 32'd0);

    // 2: TX backpressure with result 0xA5
    tx_full = 1'b1;
    w0 = total_pushes;
    push_byte(8'hA0); push_byte(8'h05); push_byte(8'h20);
    step(5);
    for (int i = 0; i < 10; i++) begin
      chk("t2_no_wr", 32'(o_wr_uart), 32'd0);
      chk("t2_w_data_hold", 32'(o_w_data), 32'hA5);
      step(1);
    end
    tx_full = 1'b0;
    #1;
    chk("t2_wr_on_release", 32'(o_wr_uart), 32'd1);
    wait_idle(20);
    chk("t2_pushes", 32'(total_pushes - w0), 32'd1);

    // 3: gapped bytes, 8-bit wrap
    w0 = total_pushes;
    push_byte(8'hFF); step(50);
    push_byte(8'h01); step(50);
    push_byte(8'h20);
    wait_idle(50);
    chk("t3_pushes", 32'(total_pushes - w0), 32'd1);
    chk("t3_result", 32'(last_wdata), 32'h00);

    // 4: back-to-back frames
    w0 = total_pushes;
    push_byte(8'h10); push_byte(8'h04); push_byte(8'h22);
    push_byte(8'h0F); push_byte(8'hF0); push_byte(8'h25);
    wait_idle(60);
    chk("t4_pushes", 32'(total_pushes - w0), 32'd2);
    chk("t4_last_result", 32'(last_wdata), 32'hFF);

    // 5: reset mid-frame
    push_byte(8'h11);
    step(2);
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    chk("t5_alu_a", 32'(o_alu_a), 32'd0);
    chk("t5_w_data", 32'(o_w_data), 32'd0);
    chk("t5_busy", 32'(o_busy), 32'd0);
    chk("t5_rd", 32'(o_rd_uart), 32'd0);
    #1;
    i_reset = 1'b0;
    w0 = total_pushes;
    push_byte(8'h02); push_byte(8'h04); push_byte(8'h20);
    wait_idle(50);
    chk("t5_pushes", 32'(total_pushes - w0), 32'd1);
    chk("t5_result", 32'(last_wdata), 32'h06);

    // 6: inter-byte timeout
    t0 = total_tmo;
    push_byte(8'h07);
    step(1);
    repeat (150) step(1);
`ifdef UART_INTF_TIMEOUT_EN
    chk("t6_tmo_pulses", 32'(total_tmo - t0), 32'd1);
    chk("t6_tmo_at_idle_100", 32'(tmo_cyc - last_pop_cyc), 32'(TMO + 1));
    chk("t6_busy_after", 32'(o_busy), 32'd0);
`else
    chk("t6_tmo_pulses", 32'(total_tmo - t0), 32'd0);
    chk("t6_still_waiting", 32'(o_busy), 32'd1);
    i_reset = 1'b1;
    step(1);
    i_reset = 1'b0;
`endif
    w0 = total_pushes;
    push_byte(8'h09); push_byte(8'h0C); push_byte(8'h24);
    wait_idle(50);
    chk("t6_pushes", 32'(total_pushes - w0), 32'd1);
    chk("t6_result", 32'(last_wdata), 32'h08);

    // Random frames with random gaps, opcode upper bits and backpressure
    w0 = total_pushes;
    for (int f = 0; f < 25; f++) begin
      for (int k = 0; k < 3; k++) begin
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (k == 2) b = ops[$urandom_range(0, 4)] | 8'($urandom_range(0, 3) << 6);
        push_byte(b);
        repeat ($urandom_range(0, 3)) begin
          tx_full = ($urandom_range(0, 2) == 0);
          step(1);
        end
      end
    end
    tx_full = 1'b0;
    wait_idle(500);
    chk("rand_pushes", 32'(total_pushes - w0), 32'd25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
